// File: rtl/crc_code_faulty_memory_pkg.sv
// ---------------------------------------------------------------------------
// crc_code_pkg
// Shared widths, the CRC-4 polynomial and the FSM state encoding for the
// CRC-protected fault-injection memory.
// ---------------------------------------------------------------------------
package crc_code_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int CRC_W  = 4;
    localparam int CW_W   = DATA_W + CRC_W;
    localparam int DEPTH  = 2 ** ADDR_W;

    // x^4 + x + 1, top term implicit
    localparam logic [CRC_W-1:0] CRC_POLY = 4'h3;

    typedef enum logic [2:0] {
        IDLE,
        W_CRC,
        W_STORE,
        R_FETCH,
        R_CRC,
        R_DONE
    } state_t;

endpackage

// File: rtl/crc_code_faulty_memory_crc4_serial_step.sv
// ---------------------------------------------------------------------------
// crc4_serial_step
// One bit of the serial CRC-4 LFSR (MSB-first, no reflection).
// Ports:
//   crc_in  - current CRC register value
//   bit_in  - next message bit
//   crc_out - CRC register after absorbing bit_in
// ---------------------------------------------------------------------------
module crc4_serial_step
    import crc_code_pkg::*;
(
    input  logic [CRC_W-1:0] crc_in,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc_out
);

    logic feedback;

    assign feedback = crc_in[CRC_W-1] ^ bit_in;
    assign crc_out  = {crc_in[CRC_W-2:0], 1'b0} ^ (feedback ? CRC_POLY : '0);

endmodule

// File: rtl/crc_code_faulty_memory.sv
// ---------------------------------------------------------------------------
// crc_code_faulty_memory
// 16 x 8-bit memory where every word is stored as a 12-bit codeword
// {crc4, data}. Writes compute the CRC serially (8 cycles) before storing.
// Reads fetch the codeword, optionally XOR a 1..4 bit burst into it,
// recompute the CRC over the (possibly corrupted) data bits and flag a
// mismatch against the (possibly corrupted) stored CRC.
// Ports:
//   clk, rst               - clock, synchronous active-low reset
//   write, read            - requests, sampled only while idle (write wins)
//   data_in, addr_in       - write data / word address
//   fault_addr             - first codeword bit of the injected burst
//   burst_error_length     - burst length minus one
//   fault_enable           - inject the burst on this read
//   mem_write_busy         - write sequence in progress
//   read_busy              - read sequence in progress
//   data_valid             - read result valid (held)
//   error_detected         - CRC mismatch on the last read (held)
//   data_out               - data bits of the fetched codeword (held)
// ---------------------------------------------------------------------------
module crc_code_faulty_memory
    import crc_code_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [ADDR_W-1:0] fault_addr,
    input  logic [1:0]        burst_error_length,
    input  logic              fault_enable,
    output logic              mem_write_busy,
    output logic              read_busy,
    output logic              data_valid,
    output logic              error_detected,
    output logic [DATA_W-1:0] data_out
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   fault_addr_q, fault_addr_d;
    logic [1:0]          burst_len_q, burst_len_d;
    logic                fault_en_q, fault_en_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [CW_W-1:0]     cw_q, cw_d;
    logic                data_valid_q, data_valid_d;
    logic                error_detected_q, error_detected_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;

    logic [CW_W-1:0]     mem_q [DEPTH];
    logic                mem_we;

    logic                step_bit;
    logic [CRC_W-1:0]    step_crc;
    logic [CW_W-1:0]     burst_mask;

    // Burst end index computed one bit wider so fault_addr=15, len=3 cannot
    // wrap back into the low bits.
    logic [ADDR_W:0]     burst_first;
    logic [ADDR_W:0]     burst_last;

    assign burst_first = {1'b0, fault_addr_q};
    assign burst_last  = burst_first + {{(ADDR_W-1){1'b0}}, burst_len_q};

    // Only indices that exist in the codeword get a mask bit, so any part of
    // the burst beyond bit CW_W-1 is simply dropped.
    generate
        for (genvar gi = 0; gi < CW_W; gi++) begin : g_mask
            localparam logic [ADDR_W:0] BIT_IDX = (ADDR_W+1)'(gi);
            assign burst_mask[gi] = fault_en_q
                                  && (BIT_IDX >= burst_first)
                                  && (BIT_IDX <= burst_last);
        end
    endgenerate

    // The write path feeds latched data, the read path feeds the fetched
    // codeword's data bits; both MSB first.
    assign step_bit = (state_q == W_CRC) ? data_q[3'd7 - cnt_q]
                                         : cw_q[3'd7 - cnt_q];

    crc4_serial_step u_step (
        .crc_in  (crc_q),
        .bit_in  (step_bit),
        .crc_out (step_crc)
    );

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        data_d           = data_q;
        fault_addr_d     = fault_addr_q;
        burst_len_d      = burst_len_q;
        fault_en_d       = fault_en_q;
        crc_d            = crc_q;
        cnt_d            = cnt_q;
        cw_d             = cw_q;
        data_valid_d     = data_valid_q;
        error_detected_d = error_detected_q;
        data_out_d       = data_out_q;
        mem_we           = 1'b0;

        case (state_q)
            IDLE: begin
                if (write) begin
                    addr_d           = addr_in;
                    data_d           = data_in;
                    crc_d            = '0;
                    cnt_d            = '0;
                    data_valid_d     = 1'b0;
                    error_detected_d = 1'b0;
                    state_d          = W_CRC;
                end else if (read) begin
                    addr_d           = addr_in;
                    fault_addr_d     = fault_addr;
                    burst_len_d      = burst_error_length;
                    fault_en_d       = fault_enable;
                    crc_d            = '0;
                    cnt_d            = '0;
                    data_valid_d     = 1'b0;
                    error_detected_d = 1'b0;
                    state_d          = R_FETCH;
                end
            end
            W_CRC: begin
                crc_d = step_crc;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = W_STORE;
                end
            end
            W_STORE: begin
                mem_we  = 1'b1;
                state_d = IDLE;
            end
            R_FETCH: begin
                cw_d    = mem_q[addr_q] ^ burst_mask;
                state_d = R_CRC;
            end
            R_CRC: begin
                crc_d = step_crc;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = R_DONE;
                end
            end
            R_DONE: begin
                data_out_d       = cw_q[DATA_W-1:0];
                error_detected_d = (crc_q != cw_q[CW_W-1:DATA_W]);
                data_valid_d     = 1'b1;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            data_q           <= '0;
            fault_addr_q     <= '0;
            burst_len_q      <= '0;
            fault_en_q       <= 1'b0;
            crc_q            <= '0;
            cnt_q            <= '0;
            cw_q             <= '0;
            data_valid_q     <= 1'b0;
            error_detected_q <= 1'b0;
            data_out_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            data_q           <= data_d;
            fault_addr_q     <= fault_addr_d;
            burst_len_q      <= burst_len_d;
            fault_en_q       <= fault_en_d;
            crc_q            <= crc_d;
            cnt_q            <= cnt_d;
            cw_q             <= cw_d;
            data_valid_q     <= data_valid_d;
            error_detected_q <= error_detected_d;
            data_out_q       <= data_out_d;
            if (mem_we) begin
                mem_q[addr_q] <= {crc_q, data_q};
            end
        end
    end

    assign mem_write_busy = (state_q == W_CRC) || (state_q == W_STORE);
    assign read_busy      = (state_q == R_FETCH) || (state_q == R_CRC)
                          || (state_q == R_DONE);
    assign data_valid     = data_valid_q;
    assign error_detected = error_detected_q;
    assign data_out       = data_out_q;

endmodule

// File: tb/tb_crc_code_faulty_memory.sv
module tb_crc_code_faulty_memory;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [7:0] data_in = '0;
    logic [3:0] addr_in = '0;
    logic [3:0] fault_addr = '0;
    logic [1:0] burst_error_length = '0;
    logic       fault_enable = 1'b0;
    logic       mem_write_busy;
    logic       read_busy;
    logic       data_valid;
    logic       error_detected;
    logic [7:0] data_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       err;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    crc_code_faulty_memory dut (
        .clk                (clk),
        .rst                (rst),
        .write              (write),
        .read               (read),
        .data_in            (data_in),
        .addr_in            (addr_in),
        .fault_addr         (fault_addr),
        .burst_error_length (burst_error_length),
        .fault_enable       (fault_enable),
        .mem_write_busy     (mem_write_busy),
        .read_busy          (read_busy),
        .data_valid         (data_valid),
        .error_detected     (error_detected),
        .data_out           (data_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: a rising data_valid is one completed read; pop and compare.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (data_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read_result actual=%0h required=none", data_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("read  %-16s data_out=%02h err=%0b (exp %02h/%0b)",
                         e.tag, data_out, error_detected, e.data, e.err);
                chk({e.tag, "_data"}, 32'(data_out), 32'(e.data));
                chk({e.tag, "_err"}, 32'(error_detected), 32'(e.err));
            end
        end
        prev_valid = data_valid;
    end

    task automatic count_write_busy(output int n);
        n = 0;
        while (mem_write_busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_read_busy(output int n);
        n = 0;
        while (read_busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, input string tag);
        int n;
        @(negedge clk);
        write = 1'b1; addr_in = a; data_in = d;
        @(negedge clk);
        write = 1'b0;
        count_write_busy(n);
        $display("write %-16s addr=%0d data=%02h busy_cycles=%0d", tag, a, d, n);
        chk({tag, "_wbusy"}, 32'(n), 32'd9);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [3:0] fa, input logic [1:0] len,
                           input logic en, input logic [7:0] exp_d, input logic exp_e,
                           input string tag);
        int n;
        exp_t e;
        e.data = exp_d; e.err = exp_e; e.tag = tag;
        exp_q.push_back(e);
        @(negedge clk);
        read = 1'b1; addr_in = a; fault_addr = fa;
        burst_error_length = len; fault_enable = en;
        @(negedge clk);
        read = 1'b0; fault_enable = 1'b0;
        count_read_busy(n);
        chk({tag, "_rbusy"}, 32'(n), 32'd10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_wbusy", 32'(mem_write_busy), 32'd0);
        chk("rst_rbusy", 32'(read_busy), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_err", 32'(error_detected), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Clean writes and reads
        do_write(4'd0, 8'hA5, "w_a5");
        chk("mem0_codeword", 32'(dut.mem_q[0]), 32'h0BA5);
        do_read(4'd0, 4'd0, 2'd0, 1'b0, 8'hA5, 1'b0, "clean0");
        do_write(4'd1, 8'h3C, "w_3c");
        do_write(4'd2, 8'h7E, "w_7e");
        do_read(4'd1, 4'd0, 2'd0, 1'b0, 8'h3C, 1'b0, "clean1");
        do_read(4'd2, 4'd0, 2'd0, 1'b0, 8'h7E, 1'b0, "clean2");

        // Single-bit faults
        do_read(4'd0, 4'd0, 2'd0, 1'b1, 8'hA4, 1'b1, "sb_a0_b0");
        do_read(4'd1, 4'd3, 2'd0, 1'b1, 8'h34, 1'b1, "sb_a1_b3");
        do_read(4'd2, 4'd7, 2'd0, 1'b1, 8'hFE, 1'b1, "sb_a2_b7");

        // Bursts of 2..4 bits, inside data, straddling, and crc-only
        do_read(4'd0, 4'd2, 2'd1, 1'b1, 8'hA9, 1'b1, "b2_a0_f2");
        do_read(4'd1, 4'd6, 2'd2, 1'b1, 8'hFC, 1'b1, "b3_a1_f6");
        do_read(4'd2, 4'd4, 2'd3, 1'b1, 8'h8E, 1'b1, "b4_a2_f4");
        do_read(4'd0, 4'd9, 2'd3, 1'b1, 8'hA5, 1'b1, "b4_a0_f9");
        do_read(4'd1, 4'd8, 2'd3, 1'b1, 8'h3C, 1'b1, "b4_a1_f8");
        do_read(4'd2, 4'd10, 2'd1, 1'b1, 8'h7E, 1'b1, "b2_a2_f10");

        // Out-of-range start and disabled injection
        do_read(4'd0, 4'd13, 2'd3, 1'b1, 8'hA5, 1'b0, "fa13");
        do_read(4'd1, 4'd5, 2'd3, 1'b0, 8'h3C, 1'b0, "fault_off");

        // Simultaneous write+read: write wins, read dropped
        @(negedge clk);
        write = 1'b1; read = 1'b1; addr_in = 4'd3; data_in = 8'h11;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        chk("both_rbusy", 32'(read_busy), 32'd0);
        count_write_busy(n);
        chk("both_wbusy", 32'(n), 32'd9);
        repeat (3) @(negedge clk);
        chk("both_no_valid", 32'(data_valid), 32'd0);
        do_read(4'd3, 4'd0, 2'd0, 1'b0, 8'h11, 1'b0, "both_rd3");

        // Requests while busy are ignored
        @(negedge clk);
        write = 1'b1; addr_in = 4'd4; data_in = 8'h22;
        @(negedge clk);
        addr_in = 4'd5; data_in = 8'h99; read = 1'b1;
        repeat (3) @(negedge clk);
        write = 1'b0; read = 1'b0;
        count_write_busy(n);
        chk("busy_wbusy", 32'(n), 32'd6);
        repeat (2) @(negedge clk);
        chk("busy_rbusy", 32'(read_busy), 32'd0);
        do_read(4'd4, 4'd0, 2'd0, 1'b0, 8'h22, 1'b0, "busy_rd4");
        do_read(4'd5, 4'd0, 2'd0, 1'b0, 8'h00, 1'b0, "busy_rd5");

        // Reset mid-write aborts and clears memory
        @(negedge clk);
        write = 1'b1; addr_in = 4'd6; data_in = 8'h55;
        @(negedge clk);
        write = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_wbusy", 32'(mem_write_busy), 32'd0);
        chk("midrst_valid", 32'(data_valid), 32'd0);
        chk("midrst_mem0", 32'(dut.mem_q[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        do_read(4'd0, 4'd0, 2'd0, 1'b0, 8'h00, 1'b0, "postrst_rd0");
        do_read(4'd6, 4'd0, 2'd0, 1'b0, 8'h00, 1'b0, "postrst_rd6");

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crc_code_faulty_memory.md
Name: crc_code_faulty_memory

Overview:
- 16-entry x 8-bit memory protected by a CRC-4 check code per word.
- Each write computes the CRC serially and stores the 12-bit codeword.
- Each read can inject a controllable 1–4 bit burst error into the fetched codeword, recomputes the CRC serially and flags mismatches.
- Used as a fault-injection demonstrator for memory protection codes.

Parameters:
- DATA_W, 8, data word width
- ADDR_W, 4, address width (DEPTH = 2**ADDR_W = 16)
- CRC_W, 4, CRC width; codeword width CW_W = DATA_W + CRC_W = 12

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (rst=0 resets on a clk edge)
- write  in  1  write request, sampled only in IDLE
- read  in  1  read request, sampled only in IDLE
- data_in  in  8  write data, latched when write is accepted
- addr_in  in  4  word address, latched when read or write is accepted
- fault_addr  in  4  codeword bit index where the burst error starts
- burst_error_length  in  2  burst length minus one (0 -> 1 bit ... 3 -> 4 bits)
- fault_enable  in  1  enable error injection on this read
- mem_write_busy  out  1  high while a write sequence runs
- read_busy  out  1  high while a read sequence runs
- data_valid  out  1  read result valid, held
- error_detected  out  1  CRC mismatch on last read, held with data_valid
- data_out  out  8  data bits of the (possibly corrupted) codeword, held

Behaviour:
- CRC definition: polynomial x^4+x+1 (CRC_POLY=4'h3), init 0, no reflection, no final XOR, data shifted MSB first. Per-bit LFSR step: fb = crc[3]^bit; crc = {crc[2:0],1'b0} ^ (fb ? 4'h3 : 0). Example: CRC(0xA5) = 4'hB; CRC(0x00) = 0.
- Codeword layout: cw[7:0] = data, cw[11:8] = crc.
- Storage: mem[16] x 12 bits, cleared to zero on reset.
- Reset (rst=0 at a clk edge):
  - FSM goes to IDLE and all outputs go to 0.
  - Memory is cleared.
  - Any operation in progress is aborted.
- FSM states: IDLE, W_CRC, W_STORE, R_FETCH, R_CRC, R_DONE.
- IDLE:
  - write=1: latch addr_in and data_in, clear crc, go to W_CRC.
  - else read=1: latch addr_in and the fault inputs, clear crc, go to R_FETCH.
  - write has priority when both are high.
  - Accepting either request clears data_valid and error_detected.
- W_CRC: 8 cycles, one data bit (MSB first) per cycle through the LFSR. Then W_STORE writes {crc, data} to mem[addr] and returns to IDLE.
- mem_write_busy is high in W_CRC and W_STORE: 9 cycles starting the cycle after accept.
- R_FETCH (1 cycle): cw = mem[addr] ^ mask, where mask = 0 if fault_enable=0.
  - Otherwise mask has bits fault_addr .. fault_addr+burst_error_length set.
  - Bits with index > 11 are dropped: no wrap-around, and fault_addr 12..15 injects nothing.
- R_CRC: 8 cycles recompute the CRC over cw[7:0], MSB first.
- R_DONE (1 cycle):
  - data_out = cw[7:0].
  - error_detected = (recomputed crc != cw[11:8]).
  - data_valid = 1; go to IDLE.
- read_busy is high in R_FETCH, R_CRC and R_DONE: 10 cycles after accept.
- data_valid, error_detected and data_out hold until the next accepted request or reset.
- Requests arriving while busy are ignored (not queued).
- Detection guarantee: any single burst of 1–4 bits inside the 12-bit codeword sets error_detected=1. A fault-free read never sets it.

Decomposition:
- Package crc_code_pkg: DATA_W, ADDR_W, CRC_W, CW_W, CRC_POLY, FSM state enum.
- One sub-module crc4_serial_step: combinational LFSR step (crc_in, bit -> crc_out), shared by the write and read paths.
- Burst-mask generation and FSM stay in the top module.

Test Plan:
- Reset, then write 0xA5 to addr 0 -> mem_write_busy high for 9 cycles; mem[0] = 12'hBA5. Read with no fault -> data_out=0xA5, error_detected=0, data_valid=1 within 10 cycles.
- Write 0x3C @1 and 0x7E @2, read each without fault -> exact data, error_detected=0.
- Single-bit faults: (addr0, bit0), (addr1, bit3), (addr2, bit7), len 0 -> data_out = data ^ (1<<bit) (0xA4, 0x34, 0xFE), error_detected=1.
- Bursts of 2, 3 and 4 bits on all three words, including crc-region starts (fault_addr 9, len 3 -> bits 9..11 only, no wrap) -> error_detected=1 every time. Data bits are flipped only when the burst falls in 0..7.
- fault_addr=13, fault_enable=1 -> no corruption, error_detected=0. fault_enable=0 with any fault_addr -> clean read.
- Simultaneous write+read in IDLE -> write performed, read dropped.
- Request while busy -> ignored.
- rst=0 mid-write -> busy flags drop and mem cleared; a read then returns 0x00 with error_detected=0.
